coin_acceptor: RTL and testbench

//  Payment front-end directly upstream of the wash-machine controller. Decodes coin

---
 rtl/wash_pkg.sv | 29 ++
 rtl/coin_tmo_cnt.sv | 25 ++
 rtl/coin_acceptor.sv | 123 ++++++++++++
 tb/tb_coin_acceptor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared state encoding, coin codes and default prices for the coin acceptor
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_PAID    = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_REFUND  = 3'd4
  } state_t;

  localparam logic [1:0] COIN_1   = 2'd0;
  localparam logic [1:0] COIN_2   = 2'd1;
  localparam logic [1:0] COIN_5   = 2'd2;
  localparam logic [1:0] COIN_BAD = 2'd3;

  localparam int DEF_PRICE_SINGLE = 4;
  localparam int DEF_PRICE_DOUBLE = 7;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  coin_value = 3'd1;
      COIN_2:  coin_value = 3'd2;
      COIN_5:  coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_tmo_cnt.sv
// rtl/coin_tmo_cnt.sv - inactivity counter; saturates at TIMEOUT_CYC-1 and flags expiry
module coin_tmo_cnt #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int TMO_W       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] count;

  assign expired = (count == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TMO_W'(1);
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin decode, credit accumulation, paid pulse, change and refund
module coin_acceptor
  import wash_pkg::*;
#(
  parameter int PRICE_SINGLE = DEF_PRICE_SINGLE,
  parameter int PRICE_DOUBLE = DEF_PRICE_DOUBLE,
  parameter int CREDIT_W     = 4,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int TMO_W        = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_coin_valid,
  input  logic [1:0]          i_coin_val,
  input  logic                i_double_wash,
  input  logic                i_cancel,
  input  logic                i_done,
  output logic                o_coin,
  output logic                o_double_wash,
  output logic                o_change_valid,
  output logic [CREDIT_W-1:0] o_change_amt,
  output logic                o_reject,
  output logic [CREDIT_W-1:0] o_credit
);

  if (PRICE_DOUBLE + 4 > (2 ** CREDIT_W) - 1) begin : g_bad_credit_w
    $error("CREDIT_W too narrow for PRICE_DOUBLE+4");
  end
  if (TIMEOUT_CYC - 1 > (2 ** TMO_W) - 1) begin : g_bad_tmo_w
    $error("TMO_W too narrow for TIMEOUT_CYC-1");
  end

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic                coin_ok;
  logic                sel_dw;
  logic [CREDIT_W:0]   value;
  logic [CREDIT_W:0]   price;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] change;
  logic                accept;
  logic                pay_now;
  logic                tmo_expired;

  assign coin_ok = i_coin_valid && (i_coin_val != COIN_BAD);
  // The price is taken from the live input only on the first coin; afterwards the latch rules.
  assign sel_dw  = (state == ST_IDLE) ? i_double_wash : o_double_wash;
  assign value   = (CREDIT_W+1)'(coin_value(i_coin_val));
  assign price   = sel_dw ? (CREDIT_W+1)'(PRICE_DOUBLE) : (CREDIT_W+1)'(PRICE_SINGLE);
  assign sum     = {1'b0, credit} + value;
  assign change  = sum[CREDIT_W-1:0] - price[CREDIT_W-1:0];
  assign accept  = coin_ok && ((state == ST_IDLE) || ((state == ST_COLLECT) && !i_cancel));
  assign pay_now = accept && (sum >= price);
  assign o_credit = credit;

  coin_tmo_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMO_W      (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != ST_COLLECT) || coin_ok),
    .en     (state == ST_COLLECT),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      credit         <= '0;
      o_coin         <= 1'b0;
      o_double_wash  <= 1'b0;
      o_change_valid <= 1'b0;
      o_change_amt   <= '0;
      o_reject       <= 1'b0;
    end else begin
      o_coin         <= 1'b0;
      o_change_valid <= 1'b0;
      o_reject       <= i_coin_valid && !accept;

      if (state == ST_IDLE && coin_ok) begin
        o_double_wash <= i_double_wash;
      end

      if (pay_now) begin
        o_coin <= 1'b1;
        credit <= '0;
        state  <= ST_PAID;
        if (change != '0) begin
          o_change_valid <= 1'b1;
          o_change_amt   <= change;
        end
      end else if (accept) begin
        credit <= sum[CREDIT_W-1:0];
        state  <= ST_COLLECT;
      end else begin
        case (state)
          ST_COLLECT: begin
            // Cancel outranks a same-cycle coin; expiry loses to any accepted coin.
            if (i_cancel || tmo_expired) begin
              o_change_valid <= 1'b1;
              o_change_amt   <= credit;
              credit         <= '0;
              o_double_wash  <= 1'b0;
              state          <= ST_REFUND;
            end
          end
          ST_PAID:   state <= ST_LOCKED;
          ST_LOCKED: begin
            if (i_done) begin
              o_double_wash <= 1'b0;
              state         <= ST_IDLE;
            end
          end
          ST_REFUND: state <= ST_IDLE;
          ST_IDLE:   state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed stimulus with a cycle-tagged event scoreboard
module tb_coin_acceptor;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_coin_valid, i_double_wash, i_cancel, i_done;
  logic [1:0] i_coin_val;
  logic       o_coin, o_double_wash, o_change_valid, o_reject;
  logic [3:0] o_change_amt, o_credit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int   cyc;
    logic coin;
    logic cv;
    int   amt;
    logic rej;
    logic dw;
    int   cr;
  } ev_t;

  ev_t sb[$];

  coin_acceptor dut (
    .clk           (clk),
    .rst           (rst),
    .i_coin_valid  (i_coin_valid),
    .i_coin_val    (i_coin_val),
    .i_double_wash (i_double_wash),
    .i_cancel      (i_cancel),
    .i_done        (i_done),
    .o_coin        (o_coin),
    .o_double_wash (o_double_wash),
    .o_change_valid(o_change_valid),
    .o_change_amt  (o_change_amt),
    .o_reject      (o_reject),
    .o_credit      (o_credit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic cv, input logic [1:0] val, input logic dw,
                     input logic cancel, input logic done);
    i_coin_valid  = cv;
    i_coin_val    = val;
    i_double_wash = dw;
    i_cancel      = cancel;
    i_done        = done;
    tick();
    i_coin_valid  = 1'b0;
    i_coin_val    = 2'd0;
    i_double_wash = 1'b0;
    i_cancel      = 1'b0;
    i_done        = 1'b0;
  endtask

  task automatic expect_ev(input int dly, input logic c, input logic v, input int amt,
                           input logic r, input logic d, input int cr);
    ev_t e;
    e.cyc = cyc + dly; e.coin = c; e.cv = v; e.amt = amt; e.rej = r; e.dw = d; e.cr = cr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (o_coin || o_change_valid || o_reject) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ev_unexpected: coin=%0b cv=%0b amt=%0d rej=%0b at cycle %0d expected no event",
                 o_coin, o_change_valid, o_change_amt, o_reject, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_coin", int'(o_coin), int'(e.coin));
        chk("ev_change_valid", int'(o_change_valid), int'(e.cv));
        if (e.cv) chk("ev_change_amt", int'(o_change_amt), e.amt);
        chk("ev_reject", int'(o_reject), int'(e.rej));
        chk("ev_double_wash", int'(o_double_wash), int'(e.dw));
        chk("ev_credit", int'(o_credit), e.cr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1;
    i_coin_valid = 1'b0; i_coin_val = 2'd0; i_double_wash = 1'b0;
    i_cancel = 1'b0; i_done = 1'b0;
    repeat (3) tick();
    chk("rst_coin", int'(o_coin), 0);
    chk("rst_cv", int'(o_change_valid), 0);
    chk("rst_amt", int'(o_change_amt), 0);
    chk("rst_reject", int'(o_reject), 0);
    chk("rst_dw", int'(o_double_wash), 0);
    chk("rst_credit", int'(o_credit), 0);
    rst = 1'b0;
    tick();

    // single wash: 2 + 2 = price 4, no change
    put(1, 2'd1, 0, 0, 0);
    chk("single_credit", int'(o_credit), 2);
    expect_ev(1, 1, 0, 0, 0, 0, 0);
    put(1, 2'd1, 0, 0, 0);
    tick();
    put(0, 2'd0, 0, 0, 1);

    // double wash: 5 + 5 = 10 against 7, change 3
    put(1, 2'd2, 1, 0, 0);
    chk("double_credit", int'(o_credit), 5);
    chk("double_dw_latched", int'(o_double_wash), 1);
    expect_ev(1, 1, 1, 3, 0, 1, 0);
    put(1, 2'd2, 0, 0, 0);
    tick();
    expect_ev(1, 0, 0, 0, 1, 1, 0);
    put(1, 2'd1, 0, 1, 0);
    repeat (5) tick();
    chk("locked_dw_held", int'(o_double_wash), 1);
    put(0, 2'd0, 0, 0, 1);
    chk("done_dw_cleared", int'(o_double_wash), 0);

    // invalid code in IDLE, cancel in IDLE ignored
    expect_ev(1, 0, 0, 0, 1, 0, 0);
    put(1, 2'd3, 0, 0, 0);
    put(0, 2'd0, 0, 1, 0);
    chk("idle_cancel_credit", int'(o_credit), 0);

    // cancel with a same-cycle coin at credit 3
    put(1, 2'd0, 0, 0, 0);
    put(1, 2'd1, 0, 0, 0);
    chk("cancel_pre_credit", int'(o_credit), 3);
    expect_ev(1, 0, 1, 3, 1, 0, 0);
    put(1, 2'd1, 0, 1, 0);
    tick();

    // inactivity timeout refunds 2
    expect_ev(1 + TMO, 0, 1, 2, 0, 0, 0);
    put(1, 2'd1, 0, 0, 0);
    repeat (TMO + 2) tick();
    chk("tmo_credit", int'(o_credit), 0);

    // coin on the expiry cycle restarts the count
    n0 = cyc;
    put(1, 2'd0, 0, 0, 0);
    while (cyc < n0 + TMO) tick();
    expect_ev(1 + TMO, 0, 1, 2, 0, 0, 0);
    put(1, 2'd0, 0, 0, 0);
    chk("tmo_restart_credit", int'(o_credit), 2);
    repeat (TMO + 2) tick();

    // reset in COLLECT with credit 3
    put(1, 2'd0, 0, 0, 0);
    put(1, 2'd1, 0, 0, 0);
    chk("rst_pre_credit", int'(o_credit), 3);
    rst = 1'b1;
    tick();
    chk("midrst_credit", int'(o_credit), 0);
    chk("midrst_cv", int'(o_change_valid), 0);
    chk("midrst_coin", int'(o_coin), 0);
    chk("midrst_dw", int'(o_double_wash), 0);
    rst = 1'b0;
    repeat (5) tick();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
